count_sequence_checker: RTL and testbench

Downstream monitor for the 4-bit down counters (ripple, synchronous, Johnson). It samples a counter's `out` bus, locks onto the legal down sequence for the selected code, and reports three things: step violations, wrap events and a saturating error tally. It sits beside the counter under test in the lab harness and is clocked from the checker's own system clock, not the counter's clock.

---
 rtl/count_sequence_checker_if.sv | 24 ++
 rtl/count_sequence_checker.sv | 140 ++++++++++++++
 tb/tb_count_sequence_checker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/count_sequence_checker_if.sv
// Observation bus between a stimulus/harness side and count_sequence_checker.
// master drives the sampled counter value and qualifiers; slave reports tracking status.
interface count_sequence_checker_if #(
   parameter int ERR_CNT_W = 8
);
   logic [3:0]           count_in;
   logic                 sample;
   logic                 mode;
   logic                 locked;
   logic                 mismatch;
   logic                 wrap;
   logic [ERR_CNT_W-1:0] err_count;
   logic [3:0]           expected;

   modport master (
      output count_in, sample, mode,
      input  locked, mismatch, wrap, err_count, expected
   );

   modport slave (
      input  count_in, sample, mode,
      output locked, mismatch, wrap, err_count, expected
   );
endinterface

// File: rtl/count_sequence_checker.sv
// Locks onto a 4-bit binary/Johnson down sequence and flags step violations, wraps and an error tally.
// All outputs registered (one edge after acceptance); SETTLE_FILTER_EN accepts only values stable for two edges.
module count_sequence_checker #(
   parameter int ERR_CNT_W = 8
) (
   input logic                     clk,
   input logic                     reset,
   count_sequence_checker_if.slave bus
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           ref_q, ref_d;
   logic                 mode_q;
   logic                 mismatch_q, mismatch_d;
   logic                 wrap_q, wrap_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic [3:0]           expected_q, expected_d;
   logic                 accept;
   logic                 v_legal;
   logic                 v_succ;
   logic                 v_wrap;

   function automatic logic is_legal(input logic [3:0] v, input logic m);
      if (!m) return 1'b1;
      case (v)
         4'b0000, 4'b0001, 4'b0011, 4'b0111,
         4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] succ(input logic [3:0] r, input logic m);
      return m ? {r[2:0], ~r[3]} : r - 4'd1;
   endfunction

`ifdef SETTLE_FILTER_EN
   // Ripple counters pass through transient codes; only a value seen on two edges counts.
   logic [3:0] settle_q;

   always_ff @(posedge clk) begin
      if (reset) settle_q <= 4'd0;
      else       settle_q <= bus.count_in;
   end

   assign accept = bus.sample && (bus.count_in == settle_q);
`else
   assign accept = bus.sample;
`endif

   always_comb begin
      state_d    = state_q;
      ref_d      = ref_q;
      mismatch_d = 1'b0;
      wrap_d     = 1'b0;
      err_d      = err_q;
      v_legal    = is_legal(bus.count_in, bus.mode);
      v_succ     = (bus.count_in == succ(ref_q, bus.mode));
      v_wrap     = v_succ && (ref_q == (bus.mode ? 4'b1000 : 4'b0000));

      if (bus.mode != mode_q) begin
         state_d = UNLOCKED;
      end else if (accept) begin
         case (state_q)
            UNLOCKED: begin
               if (v_legal) begin
                  state_d = ACQUIRE;
                  ref_d   = bus.count_in;
               end
            end
            ACQUIRE: begin
               if (bus.count_in == ref_q) begin
                  state_d = ACQUIRE;
               end else if (v_succ) begin
                  state_d = LOCKED;
                  ref_d   = bus.count_in;
                  wrap_d  = v_wrap;
               end else if (v_legal) begin
                  ref_d   = bus.count_in;
               end else begin
                  state_d = UNLOCKED;
               end
            end
            LOCKED: begin
               // Equal value means the counter is clocked slower than we sample.
               if (bus.count_in == ref_q) begin
                  state_d = LOCKED;
               end else if (v_succ) begin
                  ref_d   = bus.count_in;
                  wrap_d  = v_wrap;
               end else begin
                  mismatch_d = 1'b1;
                  if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + 1'b1;
                  if (v_legal) begin
                     state_d = ACQUIRE;
                     ref_d   = bus.count_in;
                  end else begin
                     state_d = UNLOCKED;
                  end
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end

      expected_d = (state_d == UNLOCKED) ? 4'd0 : succ(ref_d, bus.mode);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= UNLOCKED;
         ref_q      <= 4'd0;
         mode_q     <= bus.mode;
         mismatch_q <= 1'b0;
         wrap_q     <= 1'b0;
         err_q      <= '0;
         expected_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         ref_q      <= ref_d;
         mode_q     <= bus.mode;
         mismatch_q <= mismatch_d;
         wrap_q     <= wrap_d;
         err_q      <= err_d;
         expected_q <= expected_d;
      end
   end

   assign bus.locked    = (state_q == LOCKED);
   assign bus.mismatch  = mismatch_q;
   assign bus.wrap      = wrap_q;
   assign bus.err_count = err_q;
   assign bus.expected  = expected_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: binary/Johnson lock, wrap, skip, hold, mode change,
// reset, error saturation (second instance, 2-bit tally) and the optional settle filter.
module tb_count_sequence_checker;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   count_sequence_checker_if #(.ERR_CNT_W(8)) bus1();
   count_sequence_checker_if #(.ERR_CNT_W(2)) bus2();

   count_sequence_checker #(.ERR_CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   count_sequence_checker #(.ERR_CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   logic [3:0] jring [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
   logic [3:0] bad   [5] = '{4'd3, 4'd8, 4'd1, 4'd5, 4'd12};
   logic [3:0] fv    [4] = '{4'd7, 4'd3, 4'd6, 4'd5};
   logic       f_lock[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [3:0] f_exp [4] = '{4'd6, 4'd2, 4'd5, 4'd4};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] v, input logic s);
      bus1.count_in = v;
      bus1.sample   = s;
      @(posedge clk);
      #1;
   endtask

   // A settle cycle before the accepted one keeps vectors valid with or without the filter.
   task automatic feed(input logic [3:0] v);
      cyc(v, 1'b0);
      cyc(v, 1'b1);
   endtask

   task automatic cyc2(input logic [3:0] v, input logic s);
      bus1.sample   = 1'b0;
      bus2.count_in = v;
      bus2.sample   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic feed2(input logic [3:0] v);
      cyc2(v, 1'b0);
      cyc2(v, 1'b1);
   endtask

   initial begin
      int wraps;
      int mms;
      int unl;
      bus1.count_in = 4'd0; bus1.sample = 1'b0; bus1.mode = 1'b0;
      bus2.count_in = 4'd0; bus2.sample = 1'b0; bus2.mode = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked",   32'(bus1.locked),    0);
      check("rst_mismatch", 32'(bus1.mismatch),  0);
      check("rst_wrap",     32'(bus1.wrap),      0);
      check("rst_err",      32'(bus1.err_count), 0);
      check("rst_expected", 32'(bus1.expected),  0);
      reset = 1'b0;

      // Binary lock and wrap
      feed(4'd15);
      check("bin_acq_locked", 32'(bus1.locked),   0);
      check("bin_acq_exp",    32'(bus1.expected), 14);
      feed(4'd14);
      check("bin_lock",       32'(bus1.locked),   1);
      check("bin_lock_exp",   32'(bus1.expected), 13);
      wraps = 0; mms = 0; unl = 0;
      for (int i = 13; i >= 0; i--) begin
         feed(4'(i));
         wraps += int'(bus1.wrap);
         mms   += int'(bus1.mismatch);
         unl   += int'(!bus1.locked);
      end
      check("bin_no_early_wrap", 32'(wraps), 0);
      check("bin_no_mismatch",   32'(mms),   0);
      check("bin_stay_locked",   32'(unl),   0);
      feed(4'd15);
      check("bin_wrap",       32'(bus1.wrap),     1);
      check("bin_wrap_exp",   32'(bus1.expected), 14);
      feed(4'd14);
      check("bin_wrap_clr",   32'(bus1.wrap),     0);
      check("bin_err0",       32'(bus1.err_count), 0);

      // Binary skip 9 -> 7
      for (int i = 13; i >= 9; i--) feed(4'(i));
      check("skip_pre_locked", 32'(bus1.locked), 1);
      feed(4'd7);
      check("skip_mismatch",  32'(bus1.mismatch),  1);
      check("skip_err",       32'(bus1.err_count), 1);
      check("skip_locked",    32'(bus1.locked),    0);
      check("skip_exp",       32'(bus1.expected),  6);
      feed(4'd6);
      check("skip_relock",    32'(bus1.locked),    1);
      check("skip_mm_clr",    32'(bus1.mismatch),  0);

      // Johnson ring
      bus1.mode = 1'b1;
      cyc(4'd6, 1'b0);
      check("jmode_unlock",   32'(bus1.locked),    0);
      check("jmode_no_mm",    32'(bus1.mismatch),  0);
      check("jmode_exp",      32'(bus1.expected),  0);
      feed(4'b0000);
      check("j_acq_exp",      32'(bus1.expected),  4'b0001);
      feed(4'b0001);
      check("j_lock",         32'(bus1.locked),    1);
      wraps = 0; unl = 0;
      for (int i = 2; i < 8; i++) begin
         feed(jring[i]);
         wraps += int'(bus1.wrap);
         unl   += int'(!bus1.locked);
      end
      check("j_ring_nowrap",  32'(wraps), 0);
      check("j_ring_locked",  32'(unl),   0);
      feed(4'b0000);
      check("j_wrap",         32'(bus1.wrap),      1);
      check("j_wrap_exp",     32'(bus1.expected),  4'b0001);
      feed(4'b0101);
      check("j_bad_mm",       32'(bus1.mismatch),  1);
      check("j_bad_err",      32'(bus1.err_count), 2);
      check("j_bad_unlocked", 32'(bus1.locked),    0);
      check("j_bad_exp",      32'(bus1.expected),  0);
      feed(4'b0011);
      check("j_reacq_lock",   32'(bus1.locked),    0);
      check("j_reacq_exp",    32'(bus1.expected),  4'b0111);
      feed(4'b0111);
      check("j_relock",       32'(bus1.locked),    1);
      check("j_relock_exp",   32'(bus1.expected),  4'b1111);

      // Hold, mode change, reset
      bus1.mode = 1'b0;
      feed(4'd6);
      check("hold_acq_exp",   32'(bus1.expected),  5);
      feed(4'd5);
      check("hold_lock",      32'(bus1.locked),    1);
      for (int i = 0; i < 3; i++) begin
         cyc(4'd5, 1'b1);
         check("hold_mm",     32'(bus1.mismatch),  0);
         check("hold_wrap",   32'(bus1.wrap),      0);
         check("hold_locked", 32'(bus1.locked),    1);
         check("hold_exp",    32'(bus1.expected),  4);
      end
      bus1.mode = 1'b1;
      cyc(4'd5, 1'b0);
      check("mchg_locked",    32'(bus1.locked),    0);
      check("mchg_mm",        32'(bus1.mismatch),  0);
      check("mchg_err",       32'(bus1.err_count), 2);
      bus1.mode = 1'b0;
      feed(4'd5);
      feed(4'd4);
      check("pre_rst_lock",   32'(bus1.locked),    1);
      reset = 1'b1;
      cyc(4'd3, 1'b1);
      check("mid_rst_locked", 32'(bus1.locked),    0);
      check("mid_rst_mm",     32'(bus1.mismatch),  0);
      check("mid_rst_wrap",   32'(bus1.wrap),      0);
      check("mid_rst_err",    32'(bus1.err_count), 0);
      check("mid_rst_exp",    32'(bus1.expected),  0);
      reset = 1'b0;

      // Values changing every cycle
      for (int i = 0; i < 4; i++) begin
         cyc(fv[i], 1'b1);
`ifdef SETTLE_FILTER_EN
         check("filt_locked", 32'(bus1.locked),   0);
         check("filt_exp",    32'(bus1.expected), 0);
`else
         check("nofilt_locked", 32'(bus1.locked),   32'(f_lock[i]));
         check("nofilt_exp",    32'(bus1.expected), 32'(f_exp[i]));
`endif
         check("filt_mm",     32'(bus1.mismatch), 0);
      end

      // Saturation on the 2-bit tally
      feed2(4'd10);
      feed2(4'd9);
      check("sat_lock",       32'(bus2.locked),    1);
      for (int i = 0; i < 5; i++) begin
         feed2(bad[i]);
         check("sat_mm",      32'(bus2.mismatch),  1);
         check("sat_err",     32'(bus2.err_count), (i + 1 > 3) ? 3 : i + 1);
         feed2(bad[i] - 4'd1);
         check("sat_relock",  32'(bus2.locked),    1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
